// File: rtl/zad_6_2.sv
// Sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, start/ready handshake.
// Define ZAD_6_2_RADIX4_EN to retire two multiplier bits per cycle (latency ceil(WIDTH/2)).
module zad_6_2 #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     input0,
    input  logic [WIDTH-1:0]     input1,
    output logic [2*WIDTH-1:0]   output0,
    output logic                 ready
);

`ifdef ZAD_6_2_RADIX4_EN
    localparam int STEPS = (WIDTH + 1) / 2;
    localparam int SHIFT = 2;
`else
    localparam int STEPS = WIDTH;
    localparam int SHIFT = 1;
`endif
    localparam int CW = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] a;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   b;
    logic [CW-1:0]      cnt;

    // Partial product for the multiplier bits retired this cycle.
    always_comb begin
        partial = '0;
        if (b[0]) partial = a;
`ifdef ZAD_6_2_RADIX4_EN
        if (b[1]) partial = partial + (a << 1);
`endif
        acc_next = acc + partial;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            cnt     <= '0;
            output0 <= '0;
            ready   <= 1'b0;
        end else begin
            // NOTE: default-low here makes ready a single-cycle pulse without extra state.
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a     <= {{WIDTH{1'b0}}, input0};
                        b     <= input1;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    a   <= a << SHIFT;
                    b   <= b >> SHIFT;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        output0 <= acc_next;
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zad_6_2.sv
// Self-checking bench for zad_6_2: vector table, random ops against an arithmetic model,
// corner sequences (start while busy, reset mid-operation) and a back-to-back sweep.
module tb_zad_6_2;

`ifdef ZAD_6_2_RADIX4_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 24;
`endif
    // Negedges counted from the one that raises start to the one that sees ready.
    localparam int SEEN = LAT + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] input0 = '0;
    logic [23:0] input1 = '0;
    logic [47:0] output0;
    logic        ready;

    int checks = 0;
    int errors = 0;

    zad_6_2 #(.WIDTH(24)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .input0  (input0),
        .input1  (input1),
        .output0 (output0),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] x;
        logic [23:0] y;
        logic [47:0] prod;
        string       name;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [47:0] model(input logic [23:0] x, input logic [23:0] y);
        return 48'(x) * 48'(y);
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_op(input logic [23:0] x, input logic [23:0] y,
                         input logic [47:0] exp_p, input string name);
        int   k;
        logic seen;
        input0 = x;
        input1 = y;
        start  = 1'b1;
        seen   = 1'b0;
        k      = 0;
        while (!seen && k < SEEN + 10) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (ready) seen = 1'b1;
        end
        if (!seen) k = -1;
        check({name, " latency"}, 64'(k), 64'(SEEN));
        check({name, " product"}, 64'(output0), 64'(exp_p));
        @(negedge clk);
        check({name, " ready_one_cycle"}, 64'(ready), 64'(0));
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
    endtask

    initial begin
        int          k;
        int          pulses;
        int          n;
        logic        seen;
        logic [23:0] x;
        logic [23:0] y;

        vecs[0] = '{24'h000001, 24'h000001, 48'h000000000001, "one_x_one"};
        vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, "max_x_max"};
        vecs[2] = '{24'h000000, 24'h123456, 48'h000000000000, "zero_x_123456"};
        vecs[3] = '{24'hABCDEF, 24'h000000, 48'h000000000000, "abcdef_x_zero"};
        vecs[4] = '{24'h000003, 24'h000004, 48'h00000000000C, "three_x_four"};
        vecs[5] = '{24'h800000, 24'h000002, 48'h000001000000, "msb_x_two"};
        vecs[6] = '{24'h123456, 24'h000010, 48'h000001234560, "shift_by_16"};
        vecs[7] = '{24'h000001, 24'hFFFFFF, 48'h000000FFFFFF, "one_x_max"};

        // Reset state.
        #12;
        check("reset output0", 64'(output0), 64'(0));
        check("reset ready", 64'(ready), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i].x, vecs[i].y, vecs[i].prod, vecs[i].name);

        // Randomized operands, with occasional zero / all-ones corners.
        for (int i = 0; i < 40; i++) begin
            x = 24'($urandom);
            y = 24'($urandom);
            if ($urandom_range(0, 7) == 0) x = '0;
            if ($urandom_range(0, 7) == 0) y = 24'hFFFFFF;
            do_op(x, y, model(x, y), $sformatf("rand%0d %0h*%0h", i, x, y));
        end

        // start with new operands during a busy operation must be ignored.
        input0 = 24'd3;
        input1 = 24'd4;
        start  = 1'b1;
        seen   = 1'b0;
        k      = 0;
        while (!seen && k < SEEN + 10) begin
            @(negedge clk);
            k++;
            if (k == 10) begin
                input0 = 24'd5;
                input1 = 24'd7;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (ready) seen = 1'b1;
        end
        if (!seen) k = -1;
        check("busy_start latency", 64'(k), 64'(SEEN));
        check("busy_start product", 64'(output0), 64'(12));
        count_pulses(SEEN + 5, pulses);
        check("busy_start no_extra_pulse", 64'(pulses), 64'(0));
        check("busy_start output0_held", 64'(output0), 64'(12));

        // Reset mid-operation aborts the operation and clears outputs at once.
        input0 = 24'h00ABCD;
        input1 = 24'h001234;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset output0", 64'(output0), 64'(0));
        check("midreset ready", 64'(ready), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_pulses(SEEN + 5, pulses);
        check("midreset no_pulse", 64'(pulses), 64'(0));
        do_op(24'h00ABCD, 24'h001234, model(24'h00ABCD, 24'h001234), "after_reset");

        // Back-to-back sweep: start follows ready, operands increment on each pulse.
        input0 = 24'd1;
        input1 = 24'd1;
        start  = 1'b1;
        n = 0;
        k = 0;
        while (n < 1000) begin
            @(negedge clk);
            k++;
            if (ready) begin
                check($sformatf("sweep%0d latency", n), 64'(k), 64'(SEEN));
                check($sformatf("sweep%0d product", n), 64'(output0), 64'(model(input0, input1)));
                n++;
                k = 0;
                if (n < 1000) begin
                    input0 = input0 + 24'd1;
                    input1 = input1 + 24'd1;
                    start  = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end else begin
                start = 1'b0;
                if (k > SEEN + 10) begin
                    check($sformatf("sweep%0d timeout", n), 64'(k), 64'(SEEN));
                    break;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
